// File: rtl/dmem_bridge.sv
// dmem_bridge
//
// Connects the single-cycle MIPS datapath's load/store port to a slow,
// handshaked memory/IO bus. Each load or store becomes exactly one bus
// transaction. The processor is held through o_enable until the access
// resolves. Load data appears on o_mem_readdata in the cycle the processor
// is released. A bus that never answers is abandoned after TIMEOUT request
// cycles. Misaligned accesses never reach the bus. Both of these set a
// sticky error flag.
//
// Parameters
//   TIMEOUT          max cycles o_bus_req is held without i_bus_ack (>= 1)
//   ERR_DATA         load data returned when an access times out
//
// Ports
//   i_clk            clock, rising edge
//   i_reset          synchronous active-high reset
//   i_mem_rd         current instruction is a load
//   i_mem_wr         current instruction is a store (wins over i_mem_rd)
//   i_mem_addr       byte address from the ALU
//   i_mem_writedata  store data
//   o_mem_readdata   load data to the write-back mux
//   o_enable         datapath enable, 0 stalls the PC and register writes
//   o_bus_req        bus request, held until ack or timeout
//   o_bus_we         bus direction, 1 = write
//   o_bus_addr       word-aligned bus address
//   o_bus_wdata      bus write data
//   i_bus_ack        one-cycle completion strobe
//   i_bus_rdata      read data, valid with i_bus_ack
//   o_bus_err        sticky timeout / misalignment flag, cleared by reset

module dmem_bridge #(
    parameter int unsigned TIMEOUT  = 255,
    parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_mem_rd,
    input  logic        i_mem_wr,
    input  logic [31:0] i_mem_addr,
    input  logic [31:0] i_mem_writedata,
    output logic [31:0] o_mem_readdata,
    output logic        o_enable,
    output logic        o_bus_req,
    output logic        o_bus_we,
    output logic [31:0] o_bus_addr,
    output logic [31:0] o_bus_wdata,
    input  logic        i_bus_ack,
    input  logic [31:0] i_bus_rdata,
    output logic        o_bus_err
);

    localparam int unsigned CntW = $clog2(TIMEOUT + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StDone
    } state_t;

    state_t          r_state;
    logic [CntW-1:0] r_cnt;
    logic [31:0]     r_mem_readdata;
    logic            r_bus_req;
    logic            r_bus_we;
    logic [31:0]     r_bus_addr;
    logic [31:0]     r_bus_wdata;
    logic            r_bus_err;

    logic w_access;
    logic w_aligned;

    assign w_access  = i_mem_rd | i_mem_wr;
    assign w_aligned = (i_mem_addr[1:0] == 2'b00);

    // Release the datapath in DONE, or straight away for non-memory
    // instructions. Held low throughout reset.
    always_comb begin
        o_enable = 1'b0;
        if (!i_reset) begin
            if (r_state == StDone) begin
                o_enable = 1'b1;
            end else if (r_state == StIdle && !w_access) begin
                o_enable = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state        <= StIdle;
            r_cnt          <= '0;
            r_mem_readdata <= '0;
            r_bus_req      <= 1'b0;
            r_bus_we       <= 1'b0;
            r_bus_addr     <= '0;
            r_bus_wdata    <= '0;
            r_bus_err      <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (w_access) begin
                        if (w_aligned) begin
                            r_bus_addr  <= {i_mem_addr[31:2], 2'b00};
                            r_bus_wdata <= i_mem_writedata;
                            r_bus_we    <= i_mem_wr;
                            r_cnt       <= '0;
                            r_bus_req   <= 1'b1;
                            r_state     <= StBusy;
                        end else begin
                            // Trapped before reaching the bus. A load still
                            // writes back, so give it a defined zero.
                            r_bus_err <= 1'b1;
                            if (!i_mem_wr) begin
                                r_mem_readdata <= '0;
                            end
                            r_state <= StDone;
                        end
                    end
                end

                StBusy: begin
                    if (i_bus_ack) begin
                        // An ack in the last allowed cycle still completes normally
                        if (!r_bus_we) begin
                            r_mem_readdata <= i_bus_rdata;
                        end
                        r_bus_req <= 1'b0;
                        r_state   <= StDone;
                    end else if (r_cnt == CntLast) begin
                        r_bus_err <= 1'b1;
                        if (!r_bus_we) begin
                            r_mem_readdata <= ERR_DATA;
                        end
                        r_bus_req <= 1'b0;
                        r_state   <= StDone;
                    end else begin
                        r_cnt <= r_cnt + CntW'(1);
                    end
                end

                StDone: begin
                    r_state <= StIdle;
                end

                default: begin
                    r_state   <= StIdle;
                    r_bus_req <= 1'b0;
                end
            endcase
        end
    end

    assign o_mem_readdata = r_mem_readdata;
    assign o_bus_req      = r_bus_req;
    assign o_bus_we       = r_bus_we;
    assign o_bus_addr     = r_bus_addr;
    assign o_bus_wdata    = r_bus_wdata;
    assign o_bus_err      = r_bus_err;

endmodule

// File: tb/tb_dmem_bridge.sv
module tb_dmem_bridge;

    localparam int unsigned T = 4;
    localparam logic [31:0] ErrData = 32'hDEADBEEF;

    logic        i_clk;
    logic        i_reset;
    logic        i_mem_rd;
    logic        i_mem_wr;
    logic [31:0] i_mem_addr;
    logic [31:0] i_mem_writedata;
    logic [31:0] o_mem_readdata;
    logic        o_enable;
    logic        o_bus_req;
    logic        o_bus_we;
    logic [31:0] o_bus_addr;
    logic [31:0] o_bus_wdata;
    logic        i_bus_ack;
    logic [31:0] i_bus_rdata;
    logic        o_bus_err;

    int checks = 0;
    int errors = 0;

    // Reference state: what the write-back value and error flag should be
    logic [31:0] exp_rd;
    logic        exp_err;

    dmem_bridge #(
        .TIMEOUT  (T),
        .ERR_DATA (ErrData)
    ) dut (
        .i_clk           (i_clk),
        .i_reset         (i_reset),
        .i_mem_rd        (i_mem_rd),
        .i_mem_wr        (i_mem_wr),
        .i_mem_addr      (i_mem_addr),
        .i_mem_writedata (i_mem_writedata),
        .o_mem_readdata  (o_mem_readdata),
        .o_enable        (o_enable),
        .o_bus_req       (o_bus_req),
        .o_bus_we        (o_bus_we),
        .o_bus_addr      (o_bus_addr),
        .o_bus_wdata     (o_bus_wdata),
        .i_bus_ack       (i_bus_ack),
        .i_bus_rdata     (i_bus_rdata),
        .o_bus_err       (o_bus_err)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Runs one instruction from its first cycle to its release cycle.
    // ack_at = BUSY cycle (1-based) that gets the ack; > T means never.
    task automatic run_instr(input logic rd, input logic wr, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [31:0] rdata,
                             input int ack_at, input string tag);
        int exp_cyc;
        int exp_req;
        int cyc;
        int req;
        bit released;

        // Expected outcome from the access rules
        if (!(rd || wr)) begin
            exp_cyc = 1;
            exp_req = 0;
        end else if (addr[1:0] != 2'b00) begin
            exp_cyc = 2;
            exp_req = 0;
            exp_err = 1'b1;
            if (!wr) exp_rd = 32'h0;
        end else if (ack_at <= int'(T)) begin
            exp_cyc = ack_at + 2;
            exp_req = ack_at;
            if (!wr) exp_rd = rdata;
        end else begin
            exp_cyc = int'(T) + 2;
            exp_req = int'(T);
            exp_err = 1'b1;
            if (!wr) exp_rd = ErrData;
        end

        i_mem_rd        = rd;
        i_mem_wr        = wr;
        i_mem_addr      = addr;
        i_mem_writedata = wdata;
        i_bus_rdata     = rdata;
        i_bus_ack       = 1'($urandom_range(0, 1));  // stray ack, must be ignored
        cyc = 0;
        req = 0;
        released = 0;
        while (!released && cyc < 2 * int'(T) + 10) begin
            #1;
            if (o_bus_req) begin
                req++;
                check({tag, " bus_we"}, {31'b0, o_bus_we}, {31'b0, wr});
                check({tag, " bus_addr"}, o_bus_addr, addr);
                if (wr) check({tag, " bus_wdata"}, o_bus_wdata, wdata);
                i_bus_ack = (req == ack_at);
            end
            cyc++;
            if (o_enable) begin
                released = 1;
                check({tag, " readdata"}, o_mem_readdata, exp_rd);
                check({tag, " bus_err"}, {31'b0, o_bus_err}, {31'b0, exp_err});
            end
            @(negedge i_clk);
            i_bus_ack = 1'b0;
        end
        check({tag, " cycles"}, cyc, exp_cyc);
        check({tag, " req_cycles"}, req, exp_req);
        i_mem_rd = 1'b0;
        i_mem_wr = 1'b0;
    endtask

    task automatic pulse_reset();
        i_reset = 1'b1;
        @(negedge i_clk);
        i_reset = 1'b0;
        exp_rd  = 32'h0;
        exp_err = 1'b0;
    endtask

    initial begin
        logic [31:0] a;
        int k;

        i_reset = 1'b1;
        i_mem_rd = 1'b0;
        i_mem_wr = 1'b0;
        i_mem_addr = '0;
        i_mem_writedata = '0;
        i_bus_ack = 1'b0;
        i_bus_rdata = '0;
        exp_rd = '0;
        exp_err = 1'b0;

        @(negedge i_clk);
        @(negedge i_clk);
        #1;
        check("rst enable", {31'b0, o_enable}, 32'h0);
        check("rst bus_req", {31'b0, o_bus_req}, 32'h0);
        check("rst bus_we", {31'b0, o_bus_we}, 32'h0);
        check("rst bus_addr", o_bus_addr, 32'h0);
        check("rst bus_wdata", o_bus_wdata, 32'h0);
        check("rst readdata", o_mem_readdata, 32'h0);
        check("rst bus_err", {31'b0, o_bus_err}, 32'h0);
        @(negedge i_clk);
        i_reset = 1'b0;

        for (int i = 0; i < 5; i++) run_instr(1'b0, 1'b0, $urandom, $urandom, $urandom, 1, "alu");
        run_instr(1'b1, 1'b0, 32'h10010004, 32'h0, 32'h12345678, 3, "load3");
        run_instr(1'b0, 1'b1, 32'h10010008, 32'hCAFEF00D, 32'h55555555, 1, "store1");
        run_instr(1'b1, 1'b0, 32'h10010010, 32'h0, 32'h11111111, T + 1, "load_to");
        run_instr(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1, "sticky");

        // Reset during BUSY, followed by a late ack
        i_mem_rd = 1'b1;
        i_mem_addr = 32'h10010020;
        i_bus_ack = 1'b0;
        for (int i = 0; i < 3; i++) @(negedge i_clk);
        i_reset = 1'b1;
        @(negedge i_clk);
        #1;
        check("midrst bus_req", {31'b0, o_bus_req}, 32'h0);
        check("midrst readdata", o_mem_readdata, 32'h0);
        check("midrst bus_err", {31'b0, o_bus_err}, 32'h0);
        check("midrst enable", {31'b0, o_enable}, 32'h0);
        i_reset = 1'b0;
        i_mem_rd = 1'b0;
        i_bus_ack = 1'b1;
        i_bus_rdata = 32'hA5A5A5A5;
        #1;
        check("midrst idle enable", {31'b0, o_enable}, 32'h1);
        @(negedge i_clk);
        i_bus_ack = 1'b0;
        #1;
        check("late ack bus_req", {31'b0, o_bus_req}, 32'h0);
        check("late ack readdata", o_mem_readdata, 32'h0);
        check("late ack enable", {31'b0, o_enable}, 32'h1);
        exp_rd = 32'h0;
        exp_err = 1'b0;
        @(negedge i_clk);

        run_instr(1'b1, 1'b0, 32'h10010030, 32'h0, 32'h0BADF00D, T, "ack_last");
        run_instr(1'b1, 1'b1, 32'h10010034, 32'h77778888, 32'h99990000, 2, "both");
        run_instr(1'b1, 1'b0, 32'h10010002, 32'h0, 32'h13572468, 1, "misalign");
        pulse_reset();

        // Random, error-free accesses
        for (int i = 0; i < 40; i++) begin
            k = int'($urandom_range(0, 3));
            a = {$urandom} & 32'hFFFFFFFC;
            run_instr(k[0], k[1], a, $urandom, $urandom, int'($urandom_range(1, T)), "rnd");
        end
        // Random with misalignment and timeouts
        for (int i = 0; i < 30; i++) begin
            k = int'($urandom_range(0, 3));
            a = $urandom;
            if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
            run_instr(k[0], k[1], a, $urandom, $urandom, int'($urandom_range(1, T + 1)), "rnd_err");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_bridge.md
# dmem_bridge

Data-memory access bridge between the single-cycle MIPS datapath and a slow, handshaked memory/IO bus. It takes the datapath's load/store requests (address, write data, read/write strobes from the controller) and runs one bus transaction per access. It stalls the processor through the datapath's `enable` input while the access is in flight, then returns load data on `mem_readdata` in the cycle the processor is released. Each access has a timeout, and misaligned accesses are trapped and flagged.

## Interface
- `TIMEOUT`, default 255: maximum cycles `bus_req` is held without `bus_ack` before the access is aborted (≥1).
- `ERR_DATA`, default 32'hDEADBEEF: load data returned on timeout.

- `clk` in 1: single clock, all state updates on rising edge.
- `reset` in 1: synchronous, active-high; returns block to IDLE.
- `mem_rd` in 1: current instruction is a load (from controller).
- `mem_wr` in 1: current instruction is a store (from controller).
- `mem_addr` in 32: byte address from datapath ALU.
- `mem_writedata` in 32: store data from datapath.
- `mem_readdata` out 32: load data to datapath write-back mux.
- `enable` out 1: to datapath `enable`; 0 stalls PC. Controller must also gate `werf` with it.
- `bus_req` out 1: transaction request, held until ack or timeout.
- `bus_we` out 1: 1 = write, 0 = read.
- `bus_addr` out 32: word-aligned address.
- `bus_wdata` out 32: write data.
- `bus_ack` in 1: one-cycle completion strobe from bus.
- `bus_rdata` in 32: read data, valid in `bus_ack` cycle.
- `bus_err` out 1: sticky error flag (timeout or misalignment), cleared only by reset.

## Operation
- Three states: IDLE, BUSY, DONE.
- IDLE:
  - No access (`mem_rd`=`mem_wr`=0): `enable`=1; stay IDLE.
  - Access, aligned (`mem_addr[1:0]`=0): `enable`=0. Latch `bus_addr`=`mem_addr`, `bus_wdata`=`mem_writedata`, `bus_we`=`mem_wr`. Clear the timeout counter. Next state BUSY.
  - Access, misaligned: `enable`=0; no bus transaction. Set `bus_err`. For a load, load `mem_readdata`=0. Next state DONE.
- Both strobes high: treated as a write, no error.
- BUSY:
  - `bus_req`=1 and `enable`=0; bus outputs held stable.
  - On `bus_ack`: for a read, register `mem_readdata`=`bus_rdata`. Next state DONE.
  - No ack: counter increments. When counter = TIMEOUT−1 and still no ack: set `bus_err`; for a read, `mem_readdata`=ERR_DATA. Next state DONE.
  - Ack in the final timeout cycle wins: normal completion, no error.
- DONE:
  - `enable`=1 and `bus_req`=0. The datapath commits the instruction (PC advances, register file writes `mem_readdata`) at this edge. Next state IDLE.
- `bus_ack` outside BUSY is ignored.
- `mem_readdata` changes only on read completion; stores and non-memory cycles hold it.
- Counter width is $clog2(TIMEOUT+1); it never wraps, because the timeout exits first.

## Timing
- `enable` is combinational from state and strobes: 1 in DONE, 1 in IDLE with no access, else 0.
- `bus_req` is registered (asserted from BUSY entry).
- Non-memory instruction: 1 cycle.
- Memory instruction: IDLE + N BUSY + DONE, i.e. ack in first BUSY cycle gives 3 cycles total.
- Timeout instruction: TIMEOUT+2 cycles; `bus_req` is high exactly TIMEOUT cycles.
- Misaligned instruction: 2 cycles (IDLE, DONE); `bus_req` never asserts.
- Reset values: state IDLE; `bus_req`=0, `bus_we`=0, `bus_addr`=0, `bus_wdata`=0, `mem_readdata`=0, `bus_err`=0. `enable`=0 while `reset`=1.
- Reset mid-transaction: `bus_req` drops at that edge and the access is abandoned. A late `bus_ack` after reset is ignored.
- Back-to-back memory instructions: DONE→IDLE then a new access in the next cycle. No overlap; at most one transaction outstanding.

## Test plan
- ALU op, strobes low, 5 cycles → `enable`=1 every cycle, `bus_req` never high.
- Load 0x10010004, ack after 3 BUSY cycles with `bus_rdata`=0x12345678 → `bus_req` high 3 cycles, `bus_we`=0, `enable` low 4 cycles. `mem_readdata`=0x12345678 in the DONE cycle (5 cycles total).
- Store 0x10010008 data 0xCAFEF00D, ack on first BUSY cycle → `bus_we`=1, `bus_wdata`=0xCAFEF00D, 3-cycle instruction, `mem_readdata` unchanged.
- Load, no ack, TIMEOUT=4 → `bus_req` high exactly 4 cycles, `mem_readdata`=0xDEADBEEF, `bus_err`=1 and sticky. Repeat with ack in 4th cycle → no error.
- Load 0x10010002 → no `bus_req`, `bus_err`=1, `mem_readdata`=0, 2-cycle instruction.
- `reset` asserted during BUSY, then `bus_ack` next cycle → `bus_req`=0 after the reset edge, state IDLE, `mem_readdata`/`bus_err`=0, ack ignored.
